// File: rtl/ps2_command_sequencer.sv
// Host-to-keyboard PS/2 command sequencer: sends the command byte and optional argument, waits for ACK, retries on resend, times out.
// Define PS2_CMD_STATS_EN to build the saturating resend/timeout statistics counters.
module ps2_command_sequencer #(
  parameter int clkf        = 50000000,
  parameter int timeout_ms  = 20,
  parameter int max_retries = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [7:0] cmd_byte,
  input  logic       cmd_has_arg,
  input  logic [7:0] cmd_arg,
  output logic       busy,
  output logic       done,
  output logic [1:0] done_status,
  output logic [7:0] tx,
  output logic       start_tx,
  input  logic       tx_busy,
  input  logic       tx_complete,
  input  logic [7:0] rx,
  input  logic       rx_valid,
  input  logic       error,
  output logic [7:0] fwd_rx,
  output logic       fwd_rx_valid,
  output logic [7:0] stat_resends,
  output logic [7:0] stat_timeouts
);
  localparam int unsigned LIMIT = clkf / 1000 * timeout_ms;
  localparam logic [31:0] TMAX  = 32'(LIMIT - 1);
  localparam logic [7:0]  RMAX  = 8'(max_retries);
  localparam logic [7:0]  KB_ACK    = 8'hFA;
  localparam logic [7:0]  KB_RESEND = 8'hFE;

  typedef enum logic [2:0] {IDLE, SEND, WAIT_TX, WAIT_ACK, DONE} state_t;
  typedef struct packed {
    logic [7:0] cmd;
    logic       has_arg;
    logic [7:0] arg;
  } cmd_t;

  state_t      state;
  cmd_t        req;
  logic        phase;
  logic [7:0]  retry;
  logic [31:0] timer;

  logic rx_ok, ack_hit, nak_hit, retry_ok, expired, to_hit, fwd_take;

  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);

  assign rx_ok    = rx_valid & ~error;
  assign ack_hit  = (state == WAIT_ACK) & rx_ok & (rx == KB_ACK);
  // An errored byte of any value is treated like an explicit resend request.
  assign nak_hit  = (state == WAIT_ACK) & rx_valid & (error | (rx == KB_RESEND));
  assign retry_ok = (retry < RMAX);
  // >= so a forwarded byte landing on the expiry cycle only defers the timeout.
  assign expired  = (timer >= TMAX);
  assign to_hit   = expired & (((state == WAIT_TX) & ~tx_complete) |
                               ((state == WAIT_ACK) & ~rx_valid));
  assign fwd_take = rx_ok & ~((state == WAIT_ACK) & ((rx == KB_ACK) | (rx == KB_RESEND)));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fwd_rx_valid <= 1'b0;
      fwd_rx       <= 8'h00;
    end else begin
      fwd_rx_valid <= fwd_take;
      if (fwd_take) fwd_rx <= rx;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      req         <= '0;
      phase       <= 1'b0;
      retry       <= 8'h00;
      timer       <= 32'h0;
      tx          <= 8'h00;
      start_tx    <= 1'b0;
      done        <= 1'b0;
      done_status <= 2'd0;
    end else begin
      start_tx <= 1'b0;
      done     <= 1'b0;
      if (state == WAIT_TX || state == WAIT_ACK) timer <= timer + 32'd1;
      case (state)
        IDLE: if (cmd_valid) begin
          req   <= '{cmd: cmd_byte, has_arg: cmd_has_arg, arg: cmd_arg};
          phase <= 1'b0;
          retry <= 8'h00;
          state <= SEND;
        end
        SEND: if (!tx_busy) begin
          start_tx <= 1'b1;
          tx       <= phase ? req.arg : req.cmd;
          timer    <= 32'h0;
          state    <= WAIT_TX;
        end
        WAIT_TX: if (tx_complete) begin
          timer <= 32'h0;
          state <= WAIT_ACK;
        end else if (to_hit) begin
          done        <= 1'b1;
          done_status <= 2'd2;
          state       <= DONE;
        end
        WAIT_ACK: if (ack_hit) begin
          if (!phase && req.has_arg) begin
            phase <= 1'b1;
            retry <= 8'h00;
            state <= SEND;
          end else begin
            done        <= 1'b1;
            done_status <= 2'd0;
            state       <= DONE;
          end
        end else if (nak_hit) begin
          if (retry_ok) begin
            retry <= retry + 8'd1;
            state <= SEND;
          end else begin
            done        <= 1'b1;
            done_status <= 2'd1;
            state       <= DONE;
          end
        end else if (to_hit) begin
          done        <= 1'b1;
          done_status <= 2'd2;
          state       <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef PS2_CMD_STATS_EN
  logic [7:0] n_resends, n_timeouts;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      n_resends  <= 8'h00;
      n_timeouts <= 8'h00;
    end else begin
      if (nak_hit && retry_ok && n_resends != 8'hFF) n_resends  <= n_resends + 8'd1;
      if (to_hit && n_timeouts != 8'hFF)              n_timeouts <= n_timeouts + 8'd1;
    end
  end

  assign stat_resends  = n_resends;
  assign stat_timeouts = n_timeouts;
`else
  assign stat_resends  = 8'h00;
  assign stat_timeouts = 8'h00;
`endif

endmodule

// File: tb/tb_ps2_command_sequencer.sv
// Randomized directed bench for ps2_command_sequencer: a keyboard responder plus a transaction-level model of expected bytes/status.
module tb_ps2_command_sequencer;
  localparam int LIMIT = 1000;
  localparam int MAXR  = 3;
  localparam int SOK = 0, SNAK = 1, STO = 2;
`ifdef PS2_CMD_STATS_EN
  localparam bit STATS_ON = 1'b1;
`else
  localparam bit STATS_ON = 1'b0;
`endif

  logic       clk = 1'b0, reset = 1'b1;
  logic       cmd_valid = 1'b0, cmd_has_arg = 1'b0;
  logic [7:0] cmd_byte = 8'h00, cmd_arg = 8'h00;
  logic       tx_busy = 1'b0, tx_complete = 1'b0, rx_valid = 1'b0, error = 1'b0;
  logic [7:0] rx = 8'h00;
  logic       cmd_ready, busy, done, start_tx, fwd_rx_valid;
  logic [1:0] done_status;
  logic [7:0] tx, fwd_rx, stat_resends, stat_timeouts;

  ps2_command_sequencer #(.clkf(1000000), .timeout_ms(1), .max_retries(MAXR)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_byte(cmd_byte), .cmd_has_arg(cmd_has_arg), .cmd_arg(cmd_arg),
    .busy(busy), .done(done), .done_status(done_status), .tx(tx), .start_tx(start_tx),
    .tx_busy(tx_busy), .tx_complete(tx_complete), .rx(rx), .rx_valid(rx_valid),
    .error(error), .fwd_rx(fwd_rx), .fwd_rx_valid(fwd_rx_valid),
    .stat_resends(stat_resends), .stat_timeouts(stat_timeouts)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Observed traffic, sampled mid-cycle.
  logic [7:0] tx_q[$], fwd_q[$], exp_tx[$], exp_fwd[$];
  int tx_cnt = 0, done_cnt = 0, start_cyc = 0, done_cyc = 0, ack_cyc = 0;
  logic [1:0] last_status = 2'd0;
  always @(negedge clk) begin
    if (start_tx) begin tx_q.push_back(tx); tx_cnt++; start_cyc = cyc; end
    if (fwd_rx_valid) fwd_q.push_back(fwd_rx);
    if (done) begin done_cnt++; last_status = done_status; done_cyc = cyc; end
  end

  int ncomp = 0, nfail = 0;
  int mres = 0, mto = 0, tx_target = 0, done_target = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncomp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] stat_exp(input int n);
    if (!STATS_ON) return 8'h00;
    return (n > 255) ? 8'hFF : 8'(n);
  endfunction

  task automatic check_reset_values();
    check("rst cmd_ready", 32'(cmd_ready), 1);
    check("rst busy", 32'(busy), 0);
    check("rst done", 32'(done), 0);
    check("rst done_status", 32'(done_status), 0);
    check("rst start_tx", 32'(start_tx), 0);
    check("rst tx", 32'(tx), 0);
    check("rst fwd_rx_valid", 32'(fwd_rx_valid), 0);
    check("rst fwd_rx", 32'(fwd_rx), 0);
    check("rst stat_resends", 32'(stat_resends), 0);
    check("rst stat_timeouts", 32'(stat_timeouts), 0);
  endtask

  task automatic pulse_rx(input logic [7:0] b, input logic e);
    @(posedge clk); #1 rx = b; rx_valid = 1'b1; error = e;
    @(posedge clk); #1 rx_valid = 1'b0; error = 1'b0; rx = 8'h00;
  endtask

  task automatic pulse_txc();
    @(posedge clk); #1 tx_complete = 1'b1;
    @(posedge clk); #1 tx_complete = 1'b0; ack_cyc = cyc;
  endtask

  task automatic wait_start(input int target);
    for (int i = 0; i < 64 && tx_cnt < target; i++) @(posedge clk);
    check("start_tx seen", tx_cnt, target);
  endtask

  task automatic send_cmd(input logic [7:0] c, input logic h, input logic [7:0] a);
    @(posedge clk); #1;
    for (int i = 0; i < 20 && !cmd_ready; i++) begin @(posedge clk); #1; end
    check("ready before cmd", 32'(cmd_ready), 1);
    cmd_valid = 1'b1; cmd_byte = c; cmd_has_arg = h; cmd_arg = a;
    @(posedge clk); #1;
    cmd_valid = 1'b0; cmd_byte = 8'($urandom); cmd_has_arg = 1'($urandom); cmd_arg = 8'($urandom);
    check("busy after accept", 32'(busy), 1);
    check("ready low when busy", 32'(cmd_ready), 0);
  endtask

  task automatic cmp_queues(input string tag);
    check({tag, " tx count"}, tx_q.size(), exp_tx.size());
    for (int i = 0; i < tx_q.size() && i < exp_tx.size(); i++)
      check({tag, " tx byte"}, 32'(tx_q[i]), 32'(exp_tx[i]));
    check({tag, " fwd count"}, fwd_q.size(), exp_fwd.size());
    for (int i = 0; i < fwd_q.size() && i < exp_fwd.size(); i++)
      check({tag, " fwd byte"}, 32'(fwd_q[i]), 32'(exp_fwd[i]));
    tx_q.delete(); exp_tx.delete(); fwd_q.delete(); exp_fwd.delete();
  endtask

  task automatic wait_done(input int st, input int base);
    done_target++;
    for (int i = 0; i < LIMIT + 50 && done_cnt < done_target; i++) @(posedge clk);
    #1;
    check("done pulse", done_cnt, done_target);
    check("done_status", 32'(last_status), st);
    check("status held", 32'(done_status), st);
    check("done one cycle", 32'(done), 0);
    check("busy after done", 32'(busy), 0);
    check("ready after done", 32'(cmd_ready), 1);
    if (st == STO) check("timeout latency", done_cyc - base, LIMIT);
    check("stat_resends", 32'(stat_resends), 32'(stat_exp(mres)));
    check("stat_timeouts", 32'(stat_timeouts), 32'(stat_exp(mto)));
  endtask

  // fr: forced response (-1 random); ilv: 0 none, 1 byte 0x1C, 2 random interleaved byte.
  // Responses: 0-10,19 ACK; 11-14 resend; 15-16 errored byte; 17 silent after tx; 18 no tx_complete.
  task automatic run_cmd(input logic [7:0] c, input logic h, input logic [7:0] a,
                         input int fr, input int ilv);
    logic [7:0] bytes [2];
    int n, st, retry, r, base;
    bit again;
    logic [7:0] b;
    bytes[0] = c; bytes[1] = a; n = h ? 2 : 1; st = -1; base = 0;
    send_cmd(c, h, a);
    if (tx_busy) begin
      repeat (6) @(posedge clk);
      #1 check("held by tx_busy", tx_cnt, tx_target);
      tx_busy = 1'b0;
    end
    for (int p = 0; p < n && st < 0; p++) begin
      retry = 0; again = 1'b1;
      while (again) begin
        again = 1'b0;
        exp_tx.push_back(bytes[p]); tx_target++;
        wait_start(tx_target);
        r = (fr >= 0) ? fr : int'($urandom_range(0, 19));
        if (r == 18) begin
          st = STO; base = start_cyc;
        end else begin
          repeat ($urandom_range(0, 3)) @(posedge clk);
          pulse_txc();
          if (ilv == 1 || (ilv == 2 && $urandom_range(0, 2) == 0)) begin
            b = (ilv == 1) ? 8'h1C : 8'($urandom);
            if (b == 8'hFA || b == 8'hFE) b = 8'h5A;
            pulse_rx(b, 1'b0); exp_fwd.push_back(b);
          end
          if (r == 17) begin
            st = STO; base = ack_cyc;
          end else if (r <= 10 || r == 19) begin
            pulse_rx(8'hFA, 1'b0);
            if (p == n - 1) st = SOK;
          end else begin
            if (r <= 14) pulse_rx(8'hFE, 1'b0);
            else         pulse_rx(8'($urandom), 1'b1);
            if (retry < MAXR) begin retry++; mres++; again = 1'b1; end
            else st = SNAK;
          end
        end
      end
    end
    if (st == STO) mto++;
    wait_done(st, base);
    cmp_queues("cmd");
  endtask

  task automatic idle_gap();
    int k;
    logic [7:0] b;
    logic e;
    k = $urandom_range(0, 2);
    for (int i = 0; i < k; i++) begin
      b = ($urandom_range(0, 2) == 0) ? 8'hFA : 8'($urandom);
      e = ($urandom_range(0, 3) == 0);
      pulse_rx(b, e);
      if (!e) exp_fwd.push_back(b);
    end
    if ($urandom_range(0, 3) == 0) pulse_txc();
  endtask

  initial begin
    int snap;
    #12 check_reset_values();
    @(posedge clk); #1 reset = 1'b0;

    run_cmd(8'hFF, 1'b0, 8'h00, 0, 0);       // plain reset command
    tx_busy = 1'b1;
    run_cmd(8'hED, 1'b1, 8'h07, 0, 0);       // LEDs, held off by tx_busy first
    run_cmd(8'hF3, 1'b1, 8'h20, 11, 0);      // resend until NAK
    run_cmd(8'hFF, 1'b0, 8'h00, 17, 0);      // silence after tx -> timeout
    run_cmd(8'hED, 1'b1, 8'h02, 0, 1);       // scancode interleaved with ACK
    pulse_rx(8'hFA, 1'b0); exp_fwd.push_back(8'hFA);
    repeat (2) @(posedge clk);
    #1 cmp_queues("idle fa");

    for (int k = 0; k < 30; k++) begin
      idle_gap();
      run_cmd(8'($urandom), 1'($urandom), 8'($urandom), -1, 2);
    end

    // Abort in WAIT_ACK with an asynchronous reset.
    send_cmd(8'hFF, 1'b0, 8'h00);
    exp_tx.push_back(8'hFF); tx_target++;
    wait_start(tx_target);
    pulse_txc();
    pulse_rx(8'h3C, 1'b0); exp_fwd.push_back(8'h3C);
    repeat (2) @(posedge clk);
    #1 snap = done_cnt;
    @(posedge clk); #2 reset = 1'b1;
    #1 check_reset_values();
    cmp_queues("pre-reset");
    mres = 0; mto = 0;
    @(posedge clk); #1 reset = 1'b0;
    repeat (20) @(posedge clk);
    #1 check("no done after abort", done_cnt, snap);
    run_cmd(8'hED, 1'b1, 8'h04, 0, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
    $finish;
  end

  initial begin
    #950000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", ncomp);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/ps2_command_sequencer.md
Name: ps2_command_sequencer

Overview:
Sequences host-to-keyboard PS/2 commands over the shared PS2Host transmit/receive datapath. Examples are set LEDs (0xED + argument), reset (0xFF) and set typematic (0xF3 + argument). For each command it sends the byte(s), waits for the keyboard's 0xFA ACK, and handles 0xFE resend with bounded retries and a response timeout. It sits between the CPU-facing keyboard controller and PS2Host. It consumes ACK/resend bytes and forwards all other received bytes to the scancode path.

Parameters:
clkf, 50000000, input clock frequency in Hz.
timeout_ms, 20, response timeout in ms; limit = clkf/1000*timeout_ms cycles.
max_retries, 3, resends allowed per byte before failing with NAK.

Ports:
clk  input  1  system clock (sole clock)
reset  input  1  asynchronous, active-high reset
cmd_valid  input  1  command request
cmd_ready  output  1  high only in IDLE; command accepted when cmd_valid & cmd_ready
cmd_byte  input  8  command byte
cmd_has_arg  input  1  command carries one argument byte
cmd_arg  input  8  argument byte
busy  output  1  high in any state other than IDLE
done  output  1  one-cycle completion pulse
done_status  output  2  valid with done: 0=OK, 1=NAK, 2=TIMEOUT; held until next done
tx  output  8  byte to PS2Host
start_tx  output  1  one-cycle transmit strobe
tx_busy  input  1  PS2Host transmitting
tx_complete  input  1  PS2Host byte sent
rx  input  8  received byte from PS2Host
rx_valid  input  1  received byte strobe
error  input  1  receive parity/framing error, qualified by rx_valid
fwd_rx  output  8  forwarded byte
fwd_rx_valid  output  1  forwarded byte strobe (to KeyboardController)
stat_resends  output  8  see Optional Feature
stat_timeouts  output  8  see Optional Feature

Behaviour:
- Reset values: state IDLE, cmd_ready=1, busy=0, done=0, done_status=0, start_tx=0, tx=0, fwd_rx_valid=0, fwd_rx=0, retry counter 0, phase 0, timer 0, stats 0. Reset mid-command aborts immediately. No done is issued for the aborted command.
- On acceptance:
  - Latch cmd_byte, cmd_has_arg and cmd_arg.
  - Set phase=0 (command byte), retry=0.
  - Go to SEND.
- SEND:
  - Wait while tx_busy=1.
  - When tx_busy=0, drive start_tx=1 for exactly one cycle, with tx = phase ? arg : cmd (registered, held stable).
  - Go to WAIT_TX and load the timer.
- WAIT_TX:
  - On tx_complete, go to WAIT_ACK and reload the timer.
  - On timer expiry, go to DONE with TIMEOUT.
- WAIT_ACK, on rx_valid:
  - rx=0xFA with error=0:
    - If phase=0 and cmd_has_arg: phase=1, retry=0, go to SEND.
    - Otherwise: go to DONE with OK.
  - rx=0xFE, or rx_valid&error (any byte):
    - If retry<max_retries: retry+1, go to SEND with the same phase.
    - Otherwise: go to DONE with NAK.
  - Any other byte with error=0: forwarded; state unchanged; timer keeps running.
  - Timer expiry with no response: go to DONE with TIMEOUT.
- Timer:
  - Counts up from 0 each cycle in WAIT_TX/WAIT_ACK.
  - Expiry when count = limit-1.
  - rx_valid in the expiry cycle takes priority over the timeout.
- DONE: done=1 and done_status updated for one cycle, then IDLE. Earliest next acceptance is the following cycle.
- Forwarding:
  - Outside WAIT_ACK, every rx_valid&~error byte is forwarded.
  - In WAIT_ACK, 0xFA/0xFE are consumed, not forwarded.
  - rx_valid&error is never forwarded.
  - fwd_rx_valid is registered: one cycle after rx_valid, one-cycle pulse.
- cmd_valid while busy is ignored; the requester holds cmd_valid until accepted.
- tx_complete or 0xFA outside the expected state is ignored (0xFA is forwarded).

Optional Feature:
PS2_CMD_STATS_EN:
- Defined:
  - stat_resends increments on each resend taken; stat_timeouts increments on each TIMEOUT completion.
  - Both are 8-bit, saturate at 0xFF, and clear only on reset.
- Undefined: both outputs are tied to 0 and no counter logic is built.

Test Plan:
1. Reset (0xFF), no arg; bench pulses tx_complete, then rx 0xFA → exactly one start_tx with tx=0xFF, done with status 0, no fwd_rx_valid.
2. LEDs: cmd 0xED arg 0x07; ACK each byte → start_tx twice (0xED, then 0x07), done OK, busy low the cycle after done.
3. Resend: cmd 0xF3 arg 0x20, respond 0xFE four times to the first byte (max_retries=3) → four start_tx of 0xF3, done NAK; with PS2_CMD_STATS_EN, stat_resends=3.
4. Timeout: clkf=1000000, timeout_ms=1; tx_complete, then silence → done TIMEOUT exactly 1000 cycles after entering WAIT_ACK; stat_timeouts=1 when enabled.
5. Interleave: during WAIT_ACK, rx 0x1C, then 0xFA → fwd_rx=0x1C pulsed once, 0xFA consumed, done OK; rx 0xFA while IDLE → forwarded.
6. Reset asserted in WAIT_ACK → outputs return to reset values asynchronously, no done; a new command issued afterwards completes normally.
